// File: rtl/sort_pkg.sv
// Shared definitions for the bubble sort engine: default word width, FSM state type
// and the counter width helper.
package sort_pkg;

    localparam int SORT_DATA_W = 8;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } sort_state_e;

    function automatic int sort_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/compare_swap_cell.sv
// Comparator that drives the pair-swap select. Order is ascending unless
// SORT_DESC_EN is defined, which makes it descending; equal words never swap.
module compare_swap_cell
#(
    parameter int DATA_W = 8
)
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_sel
);

`ifdef SORT_DESC_EN
    assign o_sel = (i_a < i_b);
`else
    assign o_sel = (i_a > i_b);
`endif

endmodule

// File: rtl/bubble_sort_engine.sv
// Serial-load, in-place bubble sort (one compare-and-swap per clock), serial drain.
// Sort direction is chosen in compare_swap_cell by the SORT_DESC_EN macro.
module bubble_sort_engine
    import sort_pkg::*;
#(
    parameter int DATA_W = SORT_DATA_W,
    parameter int N      = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int            IW        = sort_idx_w(N);
    localparam logic [IW-1:0] LAST      = IW'(N - 1);
    localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

    sort_state_e       r_state;
    logic [DATA_W-1:0] r_mem [N];
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     r_i;
    logic [IW-1:0]     r_pass;
    logic              r_swapped;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_hi;
    logic              w_sel;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_pass_end;
    logic              w_sort_done;

    assign w_a = r_mem[r_i];
    assign w_b = r_mem[r_i + IW'(1)];

    compare_swap_cell #(.DATA_W(DATA_W)) u_cmp (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sel (w_sel)
    );

    // Pair-swap mux stage, written back to the same two slots.
    assign w_lo = w_sel ? w_b : w_a;
    assign w_hi = w_sel ? w_a : w_b;

    assign w_in_hs     = in_valid && in_ready;
    assign w_out_hs    = r_out_valid && out_ready;
    assign w_pass_end  = (r_i == (LAST_PASS - r_pass));
    assign w_sort_done = w_pass_end && (!(r_swapped || w_sel) || (r_pass == LAST_PASS));

    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state != S_LOAD);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = w_out_hs && (r_idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_i         <= '0;
            r_pass      <= '0;
            r_swapped   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int k = 0; k < N; k++) r_mem[k] <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_hs) begin
                        r_mem[r_idx] <= in_data;
                        if (r_idx == LAST) begin
                            r_state   <= S_SORT;
                            r_idx     <= '0;
                            r_i       <= '0;
                            r_pass    <= '0;
                            r_swapped <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_SORT: begin
                    r_mem[r_i]          <= w_lo;
                    r_mem[r_i + IW'(1)] <= w_hi;
                    if (w_sort_done) begin
                        r_state     <= S_DRAIN;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        // Slot 0 may be written this very cycle; forward the new value.
                        r_out_data  <= (r_i == '0) ? w_lo : r_mem[0];
                    end else if (w_pass_end) begin
                        r_i       <= '0;
                        r_pass    <= r_pass + IW'(1);
                        r_swapped <= 1'b0;
                    end else begin
                        r_i       <= r_i + IW'(1);
                        r_swapped <= r_swapped || w_sel;
                    end
                end
                S_DRAIN: begin
                    if (w_out_hs) begin
                        if (r_idx == LAST) begin
                            r_state     <= S_LOAD;
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                        end else begin
                            r_idx      <= r_idx + IW'(1);
                            r_out_data <= r_mem[r_idx + IW'(1)];
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule
